// File: rtl/alu_pkg.sv
// Shared definitions for the ALU logic datapath: logic-unit op codes and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] LU_AND   = 3'b000;
  localparam logic [2:0] LU_OR    = 3'b001;
  localparam logic [2:0] LU_XOR   = 3'b010;
  localparam logic [2:0] LU_NAND  = 3'b011;
  localparam logic [2:0] LU_NOR   = 3'b100;
  localparam logic [2:0] LU_XNOR  = 3'b101;
  localparam logic [2:0] LU_ANDN  = 3'b110;
  localparam logic [2:0] LU_PASSA = 3'b111;

  typedef enum logic [1:0] {
    LU_IDLE = 2'd0,
    LU_RUN  = 2'd1,
    LU_DONE = 2'd2
  } lu_state_e;

endpackage

// File: rtl/bitwise_lu_iter_logic_lane.sv
// Combinational LANE-bit logic slice: applies the selected op to one chunk of the operands.
module logic_lane
  import alu_pkg::*;
#(
  parameter int unsigned LANE = 8
) (
  input  logic [2:0]      op_i,
  input  logic [LANE-1:0] a_i,
  input  logic [LANE-1:0] b_i,
  output logic [LANE-1:0] y_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      LU_AND:   y_o = a_i & b_i;
      LU_OR:    y_o = a_i | b_i;
      LU_XOR:   y_o = a_i ^ b_i;
      LU_NAND:  y_o = ~(a_i & b_i);
      LU_NOR:   y_o = ~(a_i | b_i);
      LU_XNOR:  y_o = ~(a_i ^ b_i);
      LU_ANDN:  y_o = a_i & ~b_i;
      LU_PASSA: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/bitwise_lu_iter.sv
// Iterative bitwise logic unit: captures operands, evaluates LANE bits per cycle LSB first,
// and reports the result with zero/parity flags behind a valid/ready handshake.
module bitwise_lu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANE  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic             busy
);

  localparam int unsigned NCH = WIDTH / LANE;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

  lu_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] y_q, y_d;
  logic             or_q, or_d;
  logic             par_q, par_d;
  logic             zero_q;
  logic             out_valid_q, in_ready_q, busy_q;
  logic [LANE-1:0]  a_sl, b_sl, y_sl;
  logic             last;

  // Slice mux selects the chunk addressed by the counter; y_d merges the new slice back in.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    y_d  = y_q;
    for (int k = 0; k < int'(NCH); k++) begin
      if (cnt_q == CW'(k)) begin
        a_sl = a_q[k*LANE +: LANE];
        b_sl = b_q[k*LANE +: LANE];
        y_d[k*LANE +: LANE] = y_sl;
      end
    end
    last  = (cnt_q == CW'(NCH - 1));
    or_d  = or_q | (|y_sl);
    par_d = par_q ^ (^y_sl);
  end

  logic_lane #(
    .LANE (LANE)
  ) u_lane (
    .op_i (op_q),
    .a_i  (a_sl),
    .b_i  (b_sl),
    .y_o  (y_sl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LU_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      y_q         <= '0;
      or_q        <= 1'b0;
      par_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        LU_IDLE: begin
          if (in_valid && in_ready_q) begin
            op_q       <= op;
            a_q        <= a;
            b_q        <= b;
            y_q        <= '0;
            or_q       <= 1'b0;
            par_q      <= 1'b0;
            zero_q     <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= LU_RUN;
          end
        end
        LU_RUN: begin
          y_q   <= y_d;
          or_q  <= or_d;
          par_q <= par_d;
          if (last) begin
            cnt_q       <= '0;
            zero_q      <= ~or_d;
            out_valid_q <= 1'b1;
            state_q     <= LU_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LU_DONE: begin
          // in_ready stays low on the exit edge, so nothing is accepted that cycle.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= LU_IDLE;
          end
        end
        default: begin
          state_q     <= LU_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign parity    = par_q;

endmodule

// File: tb/tb_bitwise_lu_iter.sv
// Directed bench for bitwise_lu_iter: vector table on an 8-bit-lane build plus handshake,
// backpressure, mid-run reset and a single-lane (LANE=WIDTH) build.
module tb_bitwise_lu_iter;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid0, in_ready0, out_valid0, out_ready0, zero0, parity0, busy0;
  logic [2:0]  op0;
  logic [31:0] a0, b0, y0;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, zero1, parity1, busy1;
  logic [2:0]  op1;
  logic [31:0] a1, b1, y1;

  bitwise_lu_iter #(.WIDTH(32), .LANE(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .op(op0),
    .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(out_ready0), .y(y0),
    .zero(zero0), .parity(parity0), .busy(busy0)
  );

  bitwise_lu_iter #(.WIDTH(32), .LANE(32)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .op(op1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1), .y(y1),
    .zero(zero1), .parity(parity1), .busy(busy1)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        zero;
    logic        parity;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Present one op to dut0, scramble inputs right after acceptance, wait for out_valid.
  task automatic start_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready0, 1);
    op0 = o; a0 = av; b0 = bv; in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0; a0 = ~av; b0 = ~bv; op0 = ~o;
    chk("busy_in_run", busy0, 1);
    chk("in_ready_in_run", in_ready0, 0);
    lat = 0;
    while (!out_valid0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release0();
    out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0;
    chk("out_valid_after_release", out_valid0, 0);
    chk("in_ready_after_release", in_ready0, 1);
    chk("busy_after_release", busy0, 0);
  endtask

  initial begin
    int lat;
    logic [31:0] y_hold;
    logic z_hold, p_hold;

    vecs[0] = '{LU_XOR,   32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0};
    vecs[1] = '{LU_XOR,   32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{LU_NOR,   32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[3] = '{LU_AND,   32'h00000001, 32'h00000003, 32'h00000001, 1'b0, 1'b1};
    vecs[4] = '{LU_ANDN,  32'h00000001, 32'h00000003, 32'h00000000, 1'b1, 1'b0};
    vecs[5] = '{LU_OR,    32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b1};
    vecs[6] = '{LU_NAND,  32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0};
    vecs[7] = '{LU_XNOR,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 1'b1, 1'b0};
    vecs[8] = '{LU_PASSA, 32'h00000007, 32'hFFFFFFFF, 32'h00000007, 1'b0, 1'b1};
    vecs[9] = '{LU_AND,   32'h80000001, 32'h80000000, 32'h80000000, 1'b0, 1'b1};

    rst = 1'b1;
    in_valid0 = 1'b0; out_ready0 = 1'b0; op0 = '0; a0 = '0; b0 = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", in_ready0, 1);
    chk("reset_out_valid", out_valid0, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_y", y0, 0);
    chk("reset_zero", zero0, 0);
    chk("reset_parity", parity0, 0);
    chk("reset_in_ready_l32", in_ready1, 1);
    chk("reset_out_valid_l32", out_valid1, 0);

    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), lat, 4);
      chk($sformatf("v%0d_y", i), y0, vecs[i].y);
      chk($sformatf("v%0d_zero", i), zero0, vecs[i].zero);
      chk($sformatf("v%0d_parity", i), parity0, vecs[i].parity);
      release0();
    end

    // Backpressure: result held while out_ready low, in_valid ignored, no accept on exit edge.
    start_op(LU_XOR, 32'hFFFF0000, 32'h0F0F0F0F, lat);
    chk("bp_latency", lat, 4);
    y_hold = y0; z_hold = zero0; p_hold = parity0;
    chk("bp_y", y_hold, 32'hF0F00F0F);
    for (int c = 0; c < 5; c++) begin
      in_valid0 = ~in_valid0;
      a0 = $urandom; b0 = $urandom; op0 = 3'($urandom_range(7));
      @(negedge clk);
      chk("bp_y_stable", y0, y_hold);
      chk("bp_flags_stable", {zero0, parity0}, {z_hold, p_hold});
      chk("bp_out_valid", out_valid0, 1);
      chk("bp_in_ready", in_ready0, 0);
    end
    in_valid0 = 1'b1;
    out_ready0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    out_ready0 = 1'b0;
    chk("bp_exit_out_valid", out_valid0, 0);
    chk("bp_exit_busy", busy0, 0);
    chk("bp_exit_in_ready", in_ready0, 1);
    @(negedge clk);
    chk("bp_no_accept_on_exit", busy0, 0);

    // Reset after two RUN chunks, with in_valid held high across the reset edge.
    op0 = LU_AND; a0 = 32'hFFFFFFFF; b0 = 32'hFFFFFFFF; in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_run_partial_y", y0, 32'h0000FFFF);
    rst = 1'b1; in_valid0 = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid0 = 1'b0;
    chk("mid_rst_out_valid", out_valid0, 0);
    chk("mid_rst_y", y0, 0);
    chk("mid_rst_in_ready", in_ready0, 1);
    chk("mid_rst_busy", busy0, 0);
    start_op(LU_OR, 32'h12345678, 32'h00000000, lat);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_y", y0, 32'h12345678);
    release0();

    // Single-lane build: one-cycle RUN, operand change during RUN must not matter.
    @(negedge clk);
    op1 = LU_PASSA; a1 = 32'h80000000; b1 = 32'h0; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0; a1 = 32'h0; op1 = LU_AND;
    chk("l32_run_out_valid", out_valid1, 0);
    chk("l32_run_busy", busy1, 1);
    @(negedge clk);
    chk("l32_out_valid", out_valid1, 1);
    chk("l32_y", y1, 32'h80000000);
    chk("l32_parity", parity1, 1);
    chk("l32_zero", zero1, 0);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    chk("l32_release_in_ready", in_ready1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
